// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising bit-error checker for the lfsr_gen PRBS stream.
// Define PRBS_CHECKER_BITCNT_EN to add the 48-bit checked-bit counter output bit_cnt_o.
module prbs_checker #(
    parameter int unsigned         g_length      = 16,
    parameter logic [g_length-1:0] g_taps        = 'hb400,
    parameter int unsigned         g_recurse     = 1,
    parameter int unsigned         g_lock_count  = 32,
    parameter int unsigned         g_window      = 256,
    parameter int unsigned         g_unlock_errs = 8,
    parameter int unsigned         g_cnt_width   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   valid_i,
    input  logic [g_recurse-1:0]   data_i,
    input  logic                   clear_i,
    output logic                   locked_o,
    output logic                   err_o,
    output logic [g_cnt_width-1:0] err_cnt_o
`ifdef PRBS_CHECKER_BITCNT_EN
    ,
    output logic [47:0]            bit_cnt_o
`endif
);
    localparam int FW  = $clog2(g_length + 1);
    localparam int GW  = $clog2(g_lock_count + 1);
    localparam int WW  = $clog2(g_window + g_recurse + 1);
    localparam int AW  = $clog2(g_unlock_errs + g_recurse + 1);
    localparam int EW  = $clog2(g_recurse + 1);
    localparam int CW1 = g_cnt_width + 1;

    localparam logic [FW-1:0] FILL_FULL = FW'(g_length);
    localparam logic [GW-1:0] LOCK_N    = GW'(g_lock_count);
    localparam logic [WW-1:0] WIN_N     = WW'(g_window);
    localparam logic [WW-1:0] WIN_STEP  = WW'(g_recurse);
    localparam logic [AW-1:0] UNLOCK_N  = AW'(g_unlock_errs);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t                 state_q;
    logic [g_length-1:0]    hist_q, hist_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [GW-1:0]          good_q, good_d;
    logic [WW-1:0]          win_q, win_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [EW-1:0]          errs;
    logic                   err_q;
    logic [g_cnt_width-1:0] cnt_q;
    logic [CW1-1:0]         cnt_sum;

    // Unrolled per-bit walk: each bit's prediction sees the history left by earlier bits.
    always_comb begin
        logic p;
        logic chk;
        p      = 1'b0;
        chk    = 1'b0;
        hist_d = hist_q;
        fill_d = fill_q;
        good_d = good_q;
        errs   = '0;
        for (int i = 0; i < int'(g_recurse); i++) begin
            p   = ^(hist_d & g_taps);
            chk = (fill_d == FILL_FULL);
            if (state_q == SEARCH) begin
                if (chk && (data_i[i] != p))
                    good_d = '0;
                else if (chk && (good_d < LOCK_N))
                    good_d = good_d + GW'(1);
                if (fill_d != FILL_FULL)
                    fill_d = fill_d + FW'(1);
                hist_d = {hist_d[g_length-2:0], data_i[i]};
            end else begin
                errs   = errs + EW'(data_i[i] ^ p);
                hist_d = {hist_d[g_length-2:0], p};
            end
        end
    end

    assign win_d   = win_q + WIN_STEP;
    assign acc_d   = acc_q + AW'(errs);
    assign cnt_sum = {1'b0, cnt_q} + CW1'(errs);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= SEARCH;
            hist_q  <= '0;
            fill_q  <= '0;
            good_q  <= '0;
            win_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= valid_i && (state_q == LOCKED) && (errs != '0);
            if (valid_i) begin
                hist_q <= hist_d;
                case (state_q)
                    SEARCH: begin
                        fill_q <= fill_d;
                        good_q <= good_d;
                        if (good_d >= LOCK_N)
                            state_q <= LOCKED;
                    end
                    LOCKED: begin
                        if (acc_d >= UNLOCK_N) begin
                            state_q <= SEARCH;
                            fill_q  <= '0;
                            good_q  <= '0;
                            win_q   <= '0;
                            acc_q   <= '0;
                        end else if (win_d >= WIN_N) begin
                            win_q <= '0;
                            acc_q <= '0;
                        end else begin
                            win_q <= win_d;
                            acc_q <= acc_d;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
            // Clear beats a coincident errored word; err_o above still pulses.
            if (clear_i)
                cnt_q <= '0;
            else if (valid_i && (state_q == LOCKED))
                cnt_q <= cnt_sum[g_cnt_width] ? '1 : cnt_sum[g_cnt_width-1:0];
        end
    end

    assign locked_o  = (state_q == LOCKED);
    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;

`ifdef PRBS_CHECKER_BITCNT_EN
    logic [47:0] bc_q;
    logic [48:0] bc_sum;

    assign bc_sum = {1'b0, bc_q} + 49'(g_recurse);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            bc_q <= '0;
        else if (clear_i)
            bc_q <= '0;
        else if (valid_i && (state_q == LOCKED))
            bc_q <= bc_sum[48] ? '1 : bc_sum[47:0];
    end

    assign bit_cnt_o = bc_q;
`endif
endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: three instances (serial, 4-bit parallel, 4-bit counter)
// driven with recurrence-generated PRBS and checked against a queue-based model.
`timescale 1ns/1ps
module tb_prbs_checker;
    localparam logic [15:0] TAPS = 16'hb400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        va = 0, vb = 0, vc = 0, ca = 0, cb = 0, cc = 0;
    logic [0:0]  da = '0, dc = '0;
    logic [3:0]  db = '0;
    logic        la, lb, lc, ea, eb, ec;
    logic [31:0] cnta, cntb;
    logic [3:0]  cntc;
`ifdef PRBS_CHECKER_BITCNT_EN
    logic [47:0] bca, bcb, bcc;
`endif

    prbs_checker #(.g_recurse(1)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(va), .data_i(da), .clear_i(ca),
        .locked_o(la), .err_o(ea), .err_cnt_o(cnta)
`ifdef PRBS_CHECKER_BITCNT_EN
        , .bit_cnt_o(bca)
`endif
    );
    prbs_checker #(.g_recurse(4)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(vb), .data_i(db), .clear_i(cb),
        .locked_o(lb), .err_o(eb), .err_cnt_o(cntb)
`ifdef PRBS_CHECKER_BITCNT_EN
        , .bit_cnt_o(bcb)
`endif
    );
    prbs_checker #(.g_recurse(1), .g_cnt_width(4)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(vc), .data_i(dc), .clear_i(cc),
        .locked_o(lc), .err_o(ec), .err_cnt_o(cntc)
`ifdef PRBS_CHECKER_BITCNT_EN
        , .bit_cnt_o(bcc)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bit-history queues, newest at the back.
    int     R[3]    = '{1, 4, 1};
    longint CMAX[3] = '{64'hffff_ffff, 64'hffff_ffff, 64'hf};
    bit     hq[3][$];
    bit     gq[3][$];
    int     fill[3], good[3], win[3], acc[3];
    bit     mlock[3], merr[3];
    longint mcnt[3], mbc[3];

    bit         sv[3];
    bit         sc[3];
    logic [3:0] sf[3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit predq(input bit q[$]);
        bit p = 1'b0;
        for (int j = 0; j < 16; j++)
            if (TAPS[j]) p ^= q[q.size() - 1 - j];
        return p;
    endfunction

    function automatic bit gen_bit(input int id);
        bit b = predq(gq[id]);
        gq[id].push_back(b);
        void'(gq[id].pop_front());
        return b;
    endfunction

    task automatic model_reset(input int id);
        hq[id].delete();
        for (int j = 0; j < 16; j++) hq[id].push_back(1'b0);
        fill[id] = 0; good[id] = 0; win[id] = 0; acc[id] = 0;
        mlock[id] = 0; merr[id] = 0; mcnt[id] = 0; mbc[id] = 0;
    endtask

    task automatic model_word(input int id, input bit v, input logic [3:0] d, input bit clr);
        int errs = 0;
        bit p, b, was;
        if (!v) begin
            merr[id] = 0;
        end else begin
            was = mlock[id];
            for (int i = 0; i < R[id]; i++) begin
                p = predq(hq[id]);
                b = d[i];
                if (!was) begin
                    if (fill[id] == 16) good[id] = (b != p) ? 0 : good[id] + 1;
                    hq[id].push_back(b);
                    if (fill[id] < 16) fill[id]++;
                end else begin
                    if (b != p) errs++;
                    hq[id].push_back(p);
                end
                void'(hq[id].pop_front());
            end
            if (!was) begin
                merr[id] = 0;
                if (good[id] >= 32) mlock[id] = 1;
            end else begin
                merr[id] = (errs > 0);
                mcnt[id] = (mcnt[id] + errs > CMAX[id]) ? CMAX[id] : mcnt[id] + errs;
                mbc[id]  = mbc[id] + R[id];
                if (acc[id] + errs >= 8) begin
                    mlock[id] = 0; fill[id] = 0; good[id] = 0; win[id] = 0; acc[id] = 0;
                end else begin
                    win[id] += R[id];
                    if (win[id] >= 256) begin win[id] = 0; acc[id] = 0; end
                    else acc[id] += errs;
                end
            end
        end
        if (clr) begin mcnt[id] = 0; mbc[id] = 0; end
    endtask

    task automatic check_all();
        chk("A_locked", la, mlock[0]); chk("A_err", ea, merr[0]); chk("A_cnt", cnta, mcnt[0]);
        chk("B_locked", lb, mlock[1]); chk("B_err", eb, merr[1]); chk("B_cnt", cntb, mcnt[1]);
        chk("C_locked", lc, mlock[2]); chk("C_err", ec, merr[2]); chk("C_cnt", cntc, mcnt[2]);
`ifdef PRBS_CHECKER_BITCNT_EN
        chk("A_bitcnt", bca, mbc[0]); chk("B_bitcnt", bcb, mbc[1]); chk("C_bitcnt", bcc, mbc[2]);
`endif
    endtask

    // One clock: build words from the generators, apply error masks, update model, compare.
    task automatic step();
        logic [3:0] w[3];
        for (int id = 0; id < 3; id++) begin
            w[id] = '0;
            if (sv[id]) begin
                for (int i = 0; i < R[id]; i++) w[id][i] = gen_bit(id);
                w[id] = w[id] ^ sf[id];
            end
            model_word(id, sv[id], w[id], sc[id]);
        end
        va = sv[0]; da = w[0][0:0]; ca = sc[0];
        vb = sv[1]; db = w[1];      cb = sc[1];
        vc = sv[2]; dc = w[2][0:0]; cc = sc[2];
        @(posedge clk); #1;
        check_all();
        for (int id = 0; id < 3; id++) begin sv[id] = 0; sc[id] = 0; sf[id] = '0; end
    endtask

    task automatic clean_a(input int n);
        for (int k = 0; k < n; k++) begin sv[0] = 1; step(); end
    endtask

    initial begin
        int nb;
        for (int id = 0; id < 3; id++) begin
            model_reset(id);
            sv[id] = 0; sc[id] = 0; sf[id] = '0;
            for (int j = 0; j < 16; j++) gq[id].push_back(1'($urandom));
            gq[id][0] = 1'b1;
        end

        // Reset state
        #12;
        check_all();
        chk("rst_A_locked", la, 0); chk("rst_B_cnt", cntb, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Serial lock on A and C, 1-in-4 gapped parallel lock on B
        nb = 0;
        for (int k = 1; k <= 48; k++) begin
            sv[0] = 1; sv[2] = 1; sv[1] = (k % 4 == 1);
            if (sv[1]) nb++;
            step();
            if (k == 47) chk("A_unlocked_at_47", la, 0);
            if (k == 48) chk("A_locked_at_48", la, 1);
            if (vb && nb == 11) chk("B_unlocked_at_11w", lb, 0);
            if (vb && nb == 12) chk("B_locked_at_12w", lb, 1);
        end
        chk("B_cnt_after_lock", cntb, 0);
        clean_a(10000);
        chk("A_cnt_10000_clean", cnta, 0);

        // Single error on A (serial) and B (4-bit word): count 1, no multiplication
        sv[0] = 1; sf[0] = 4'b0001; step();
        chk("A_single_err_pulse", ea, 1); chk("A_single_cnt", cnta, 1); chk("A_single_lock", la, 1);
        sv[0] = 1; step();
        chk("A_err_one_cycle", ea, 0);
        sv[1] = 1; sf[1] = 4'b0100; step();
        chk("B_single_err_pulse", eb, 1); chk("B_single_cnt", cntb, 1);
        for (int k = 0; k < 50; k++) begin sv[0] = 1; sv[1] = 1; step(); end
        chk("A_cnt_no_mult", cnta, 1); chk("B_cnt_no_mult", cntb, 1); chk("B_still_locked", lb, 1);

        // 8 errors inside one window drop lock on A; then relock after 48 clean bits
        clean_a(300);
        for (int k = 0; k < 300 && win[0] != 0; k++) clean_a(1);
        chk("A_window_aligned", win[0], 0);
        for (int e = 0; e < 8; e++) begin
            sv[0] = 1; sf[0] = 4'b0001; step();
            if (e == 6) chk("A_locked_after_7", la, 1);
            if (e == 7) chk("A_unlocked_after_8", la, 0);
            if (e < 7) clean_a(7);
        end
        for (int k = 1; k <= 48; k++) begin
            clean_a(1);
            if (k == 47) chk("A_relock_not_at_47", la, 0);
            if (k == 48) chk("A_relock_at_48", la, 1);
        end

        // 7 errors per window over 4 windows keeps lock
        sv[0] = 1; sc[0] = 1; step();
        chk("A_cleared", cnta, 0);
        for (int k = 0; k < 300 && win[0] != 0; k++) clean_a(1);
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 256; b++) begin
                sv[0] = 1;
                sf[0] = (b % 32 == 0 && b < 224) ? 4'b0001 : 4'b0000;
                step();
            end
        chk("A_cnt_28", cnta, 28); chk("A_lock_kept_28", la, 1);

        // Saturation of the 4-bit counter on C, then clear on an errored word
        for (int e = 0; e < 20; e++) begin
            sv[2] = 1; sf[2] = 4'b0001; step();
            for (int k = 0; k < 39; k++) begin sv[2] = 1; step(); end
        end
        chk("C_cnt_saturated", cntc, 15); chk("C_still_locked", lc, 1);
        sv[2] = 1; sf[2] = 4'b0001; sc[2] = 1; step();
        chk("C_clear_wins", cntc, 0); chk("C_err_pulse_on_clear", ec, 1);

        // Randomized gaps, sparse errors and clears on B
        for (int k = 0; k < 600; k++) begin
            sv[1] = 1'($urandom_range(0, 1));
            sf[1] = ($urandom_range(0, 49) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            sc[1] = ($urandom_range(0, 199) == 0);
            step();
        end

        // Asynchronous reset mid-lock
        chk("A_locked_before_rst", la, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_A_locked", la, 0); chk("rst_async_A_cnt", cnta, 0);
        chk("rst_async_B_locked", lb, 0); chk("rst_async_C_locked", lc, 0);
        for (int id = 0; id < 3; id++) model_reset(id);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 48; k++) begin
            clean_a(1);
            if (k == 47) chk("A_post_rst_not_47", la, 0);
            if (k == 48) chk("A_post_rst_lock_48", la, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
